// File: rtl/sdram_access_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_access_arbiter
//
// Two single-entry request slots (write from the capture side, read from the
// consumer side) share one SDRAM controller. A one-hot FSM grants one slot at
// a time, alternating when both are waiting. Write has priority after reset.
// Each access is bounded by a cycle counter. If no ack arrives in time, the
// access is dropped and a sticky timeout flag is raised.
//
// Ports
//   iclk, ireset             clock, asynchronous active-high reset
//   iwr_valid/addr/data      write request in; owr_busy = write slot occupied
//   ird_valid/addr           read request in;  ord_busy = read slot occupied
//   ord_data, ord_valid      last completed read data, one-cycle update pulse
//   owrite_req/address/data  write request to controller; iwrite_ack back
//   oread_req/address        read request to controller; iread_data/ack back
//   otimeout                 sticky: an access was abandoned
// -----------------------------------------------------------------------------
module sdram_access_arbiter #(
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iwr_valid,
  input  logic [ADDR_W-1:0] iwr_addr,
  input  logic [DATA_W-1:0] iwr_data,
  output logic              owr_busy,
  input  logic              ird_valid,
  input  logic [ADDR_W-1:0] ird_addr,
  output logic              ord_busy,
  output logic [DATA_W-1:0] ord_data,
  output logic              ord_valid,
  output logic              owrite_req,
  output logic [ADDR_W-1:0] owrite_address,
  output logic [DATA_W-1:0] owrite_data,
  input  logic              iwrite_ack,
  output logic              oread_req,
  output logic [ADDR_W-1:0] oread_address,
  input  logic [DATA_W-1:0] iread_data,
  input  logic              iread_ack,
  output logic              otimeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    WRITE = 5'b00010,
    WDONE = 5'b00100,
    READ  = 5'b01000,
    RDONE = 5'b10000
  } state_t;

  state_t state_reg, state_next;

  logic              wr_busy_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              rd_busy_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg;
  logic              wr_req_reg;
  logic              rd_req_reg;
  logic              timeout_reg;
  logic              rr_read_reg;   // 1: read wins the next tie
  logic [CNT_W-1:0]  cnt_reg;

  logic cnt_done;
  logic wr_take;
  logic rd_take;
  logic abort;

  assign cnt_done = (cnt_reg == CNT_LAST);

  // A slot refills only while idle. During its DONE cycle the busy flag is
  // already low, but a new request that cycle is still ignored.
  assign wr_take = iwr_valid && !wr_busy_reg && (state_reg != WDONE);
  assign rd_take = ird_valid && !rd_busy_reg && (state_reg != RDONE);

  always_comb begin
    state_next = state_reg;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wr_busy_reg && rd_busy_reg)
          state_next = rr_read_reg ? READ : WRITE;
        else if (wr_busy_reg)
          state_next = WRITE;
        else if (rd_busy_reg)
          state_next = READ;
      end
      WRITE: begin
        // If the ack and the last allowed cycle coincide, the ack wins.
        if (iwrite_ack)
          state_next = WDONE;
        else if (cnt_done) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      WDONE: state_next = IDLE;
      READ: begin
        if (iread_ack)
          state_next = RDONE;
        else if (cnt_done) begin
          state_next = IDLE;
          abort      = 1'b1;
        end
      end
      RDONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_reg    <= IDLE;
      wr_busy_reg  <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      rd_busy_reg  <= 1'b0;
      rd_addr_reg  <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      wr_req_reg   <= 1'b0;
      rd_req_reg   <= 1'b0;
      timeout_reg  <= 1'b0;
      rr_read_reg  <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg <= state_next;

      // Controller strobes track the state being entered, so they are
      // registered and can never be high together.
      wr_req_reg   <= (state_next == WRITE);
      rd_req_reg   <= (state_next == READ);
      rd_valid_reg <= (state_next == RDONE);

      if (wr_take) begin
        wr_busy_reg <= 1'b1;
        wr_addr_reg <= iwr_addr;
        wr_data_reg <= iwr_data;
      end else if (state_reg == WRITE && state_next != WRITE) begin
        wr_busy_reg <= 1'b0;
      end

      if (rd_take) begin
        rd_busy_reg <= 1'b1;
        rd_addr_reg <= ird_addr;
      end else if (state_reg == READ && state_next != READ) begin
        rd_busy_reg <= 1'b0;
      end

      if (state_reg == READ && iread_ack)
        rd_data_reg <= iread_data;

      if (abort)
        timeout_reg <= 1'b1;

      // Counter runs only while staying in an access state. It restarts at
      // zero on every entry, since both access states are entered from IDLE.
      if ((state_reg == WRITE && state_next == WRITE) ||
          (state_reg == READ  && state_next == READ))
        cnt_reg <= cnt_reg + 1'b1;
      else
        cnt_reg <= '0;

      if (state_reg == IDLE && state_next == WRITE)
        rr_read_reg <= 1'b1;
      else if (state_reg == IDLE && state_next == READ)
        rr_read_reg <= 1'b0;
    end
  end

  assign owr_busy       = wr_busy_reg;
  assign ord_busy       = rd_busy_reg;
  assign ord_data       = rd_data_reg;
  assign ord_valid      = rd_valid_reg;
  assign owrite_req     = wr_req_reg;
  assign owrite_address = wr_addr_reg;
  assign owrite_data    = wr_data_reg;
  assign oread_req      = rd_req_reg;
  assign oread_address  = rd_addr_reg;
  assign otimeout       = timeout_reg;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_access_arbiter
// Directed bench for sdram_access_arbiter with a short timeout so that
// abandoned accesses resolve quickly. Inputs are driven and outputs are sampled
// 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_sdram_access_arbiter;

  localparam int ADDR_W  = 22;
  localparam int DATA_W  = 128;
  localparam int TIMEOUT = 16;

  logic              iclk = 1'b0;
  logic              ireset;
  logic              iwr_valid;
  logic [ADDR_W-1:0] iwr_addr;
  logic [DATA_W-1:0] iwr_data;
  logic              owr_busy;
  logic              ird_valid;
  logic [ADDR_W-1:0] ird_addr;
  logic              ord_busy;
  logic [DATA_W-1:0] ord_data;
  logic              ord_valid;
  logic              owrite_req;
  logic [ADDR_W-1:0] owrite_address;
  logic [DATA_W-1:0] owrite_data;
  logic              iwrite_ack;
  logic              oread_req;
  logic [ADDR_W-1:0] oread_address;
  logic [DATA_W-1:0] iread_data;
  logic              iread_ack;
  logic              otimeout;

  int n_total = 0;
  int n_pass  = 0;
  int overlap = 0;

  sdram_access_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .iclk          (iclk),
    .ireset        (ireset),
    .iwr_valid     (iwr_valid),
    .iwr_addr      (iwr_addr),
    .iwr_data      (iwr_data),
    .owr_busy      (owr_busy),
    .ird_valid     (ird_valid),
    .ird_addr      (ird_addr),
    .ord_busy      (ord_busy),
    .ord_data      (ord_data),
    .ord_valid     (ord_valid),
    .owrite_req    (owrite_req),
    .owrite_address(owrite_address),
    .owrite_data   (owrite_data),
    .iwrite_ack    (iwrite_ack),
    .oread_req     (oread_req),
    .oread_address (oread_address),
    .iread_data    (iread_data),
    .iread_ack     (iread_ack),
    .otimeout      (otimeout)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk)
    if (owrite_req && oread_req) overlap++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  // Called in the first cycle of WRITE; returns in the WDONE cycle.
  task automatic complete_write(input int hold);
    repeat (hold - 1) step();
    iwrite_ack = 1'b1;
    step();
    iwrite_ack = 1'b0;
  endtask

  // Called in the first cycle of READ; returns in the RDONE cycle.
  task automatic complete_read(input int hold, input logic [DATA_W-1:0] d);
    repeat (hold - 1) step();
    iread_data = d;
    iread_ack  = 1'b1;
    step();
    iread_ack  = 1'b0;
  endtask

  task automatic do_both(input logic write_first, input logic [DATA_W-1:0] rdat);
    $display("both: wr_addr=4 rd_addr=5 expect %s first", write_first ? "write" : "read");
    iwr_valid = 1'b1; iwr_addr = 22'd4; iwr_data = 128'hAA;
    ird_valid = 1'b1; ird_addr = 22'd5;
    step();
    iwr_valid = 1'b0; ird_valid = 1'b0;
    step();
    check("both_first_wr", owrite_req, write_first);
    check("both_first_rd", oread_req, !write_first);
    if (write_first) begin
      complete_write(2);
      step();
      step();
      check("both_second_rd", oread_req, 1'b1);
      complete_read(2, rdat);
      check("both_rdata", ord_data, rdat);
      step();
    end else begin
      complete_read(2, rdat);
      check("both_rdata", ord_data, rdat);
      step();
      step();
      check("both_second_wr", owrite_req, 1'b1);
      check("both_wdata", owrite_data, 128'hAA);
      complete_write(2);
      step();
    end
  endtask

  initial begin
    int cnt;
    int guard;
    ireset = 1'b1;
    iwr_valid = 1'b0; iwr_addr = '0; iwr_data = '0;
    ird_valid = 1'b0; ird_addr = '0;
    iwrite_ack = 1'b0; iread_ack = 1'b0; iread_data = '0;
    repeat (2) step();

    $display("reset state");
    check("rst_wr_busy", owr_busy, 1'b0);
    check("rst_rd_busy", ord_busy, 1'b0);
    check("rst_wreq", owrite_req, 1'b0);
    check("rst_rreq", oread_req, 1'b0);
    check("rst_timeout", otimeout, 1'b0);
    check("rst_wdata", owrite_data, 128'h0);
    ireset = 1'b0;
    step();

    // Write 0xDEADBEEF to address 1, ack in the fifth request cycle.
    $display("write addr=1 data=deadbeef ack after 5");
    iwr_valid = 1'b1; iwr_addr = 22'd1; iwr_data = 128'hDEADBEEF;
    step();
    iwr_valid = 1'b0;
    check("wr_latched_busy", owr_busy, 1'b1);
    check("wr_req_not_yet", owrite_req, 1'b0);
    step();
    check("wr_req_high", owrite_req, 1'b1);
    check("wr_addr", owrite_address, 22'd1);
    check("wr_data", owrite_data, 128'hDEADBEEF);
    cnt = 1;
    repeat (4) begin
      step();
      if (owrite_req) cnt++;
    end
    iwrite_ack = 1'b1;
    step();
    iwrite_ack = 1'b0;
    check("wr_req_cycles", cnt, 5);
    check("wdone_req_low", owrite_req, 1'b0);
    check("wdone_busy_clr", owr_busy, 1'b0);
    // A request in the WDONE cycle is ignored; the next cycle accepts it.
    iwr_valid = 1'b1; iwr_addr = 22'd9; iwr_data = 128'h77;
    step();
    check("wdone_req_ignored", owr_busy, 1'b0);
    step();
    iwr_valid = 1'b0;
    check("after_done_accept", owr_busy, 1'b1);
    step();
    check("after_done_data", owrite_data, 128'h77);
    complete_write(1);
    step();

    // Read from address 1, ack with 0x23 after 3 cycles.
    $display("read addr=1 data=23 ack after 3");
    ird_valid = 1'b1; ird_addr = 22'd1;
    step();
    ird_valid = 1'b0;
    check("rd_latched_busy", ord_busy, 1'b1);
    step();
    check("rd_req_high", oread_req, 1'b1);
    check("rd_addr", oread_address, 22'd1);
    check("rd_no_wreq", owrite_req, 1'b0);
    complete_read(3, 128'h23);
    check("rdone_valid", ord_valid, 1'b1);
    check("rdone_data", ord_data, 128'h23);
    check("rdone_busy_clr", ord_busy, 1'b0);
    check("rdone_req_low", oread_req, 1'b0);
    step();
    check("rd_valid_pulse", ord_valid, 1'b0);

    // Read ack outside READ must not change anything.
    $display("stray read ack in idle");
    iread_data = 128'h99; iread_ack = 1'b1;
    step();
    iread_ack = 1'b0;
    check("stray_ack_data", ord_data, 128'h23);
    check("stray_ack_valid", ord_valid, 1'b0);

    do_both(1'b1, 128'h31);
    do_both(1'b1, 128'h32);

    // Second write while busy is dropped.
    $display("write 11 then 55 while busy");
    iwr_valid = 1'b1; iwr_addr = 22'd2; iwr_data = 128'h11;
    step();
    iwr_addr = 22'd3; iwr_data = 128'h55;
    step();
    iwr_valid = 1'b0;
    check("drop_wdata", owrite_data, 128'h11);
    check("drop_waddr", owrite_address, 22'd2);
    complete_write(2);
    step();

    // Last grant was the write, so a tie now goes to the read.
    do_both(1'b0, 128'h33);

    // Ack exactly in the last allowed cycle completes normally.
    $display("write with ack on the timeout cycle");
    iwr_valid = 1'b1; iwr_addr = 22'd6; iwr_data = 128'h66;
    step();
    iwr_valid = 1'b0;
    step();
    complete_write(TIMEOUT);
    check("edge_ack_wins", otimeout, 1'b0);
    step();

    // No ack: write abandoned after TIMEOUT request cycles.
    $display("write with no ack -> timeout");
    iwr_valid = 1'b1; iwr_addr = 22'd8; iwr_data = 128'h88;
    step();
    iwr_valid = 1'b0;
    step();
    cnt = 0; guard = 0;
    while (owrite_req && guard < 100) begin
      cnt++; guard++;
      step();
    end
    check("to_req_cycles", cnt, TIMEOUT);
    check("to_flag", otimeout, 1'b1);
    check("to_busy_clr", owr_busy, 1'b0);
    check("to_no_valid", ord_valid, 1'b0);
    ird_valid = 1'b1; ird_addr = 22'd10;
    step();
    ird_valid = 1'b0;
    step();
    check("to_read_req", oread_req, 1'b1);
    complete_read(2, 128'h44);
    check("to_read_data", ord_data, 128'h44);
    check("to_flag_sticky", otimeout, 1'b1);
    step();

    // Reset in the middle of a read.
    $display("reset during read");
    ird_valid = 1'b1; ird_addr = 22'd7;
    step();
    ird_valid = 1'b0;
    step();
    check("rst_mid_req_up", oread_req, 1'b1);
    step();
    ireset = 1'b1;
    #1;
    check("async_rreq", oread_req, 1'b0);
    check("async_rbusy", ord_busy, 1'b0);
    check("async_rvalid", ord_valid, 1'b0);
    check("async_timeout", otimeout, 1'b0);
    ird_valid = 1'b1;
    step();
    check("rst_req_ignored", ord_busy, 1'b0);
    ird_valid = 1'b0;
    ireset = 1'b0;
    iread_data = 128'h66; iread_ack = 1'b1;
    step();
    iread_ack = 1'b0;
    check("late_ack_valid", ord_valid, 1'b0);
    check("late_ack_data", ord_data, 128'h0);
    check("late_ack_req", oread_req, 1'b0);
    step();
    check("late_ack_valid2", ord_valid, 1'b0);

    check("no_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdram_access_arbiter.md
SDRAM_ACCESS_ARBITER -- requirements
Module: sdram_access_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 22, SDRAM word address width.
REQ-002 The block SHALL have parameter DATA_W, default 128, SDRAM burst data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, the number of cycles allowed for a controller ack.
REQ-004 The block SHALL have the following ports, in this order:
- iclk  in  1  system clock, single clock domain.
- ireset  in  1  asynchronous, active-high reset.
- iwr_valid  in  1  write request from the capture side, sampled each cycle.
- iwr_addr  in  ADDR_W  write address.
- iwr_data  in  DATA_W  write data.
- owr_busy  out  1  write slot occupied.
- ird_valid  in  1  read request from the consumer side.
- ird_addr  in  ADDR_W  read address.
- ord_busy  out  1  read slot occupied.
- ord_data  out  DATA_W  last completed read data.
- ord_valid  out  1  one-cycle pulse when ord_data updates.
- owrite_req  out  1  write request to the SDRAM controller.
- owrite_address  out  ADDR_W  write address to the controller.
- owrite_data  out  DATA_W  write data to the controller.
- iwrite_ack  in  1  write completion from the controller.
- oread_req  out  1  read request to the controller.
- oread_address  out  ADDR_W  read address to the controller.
- iread_data  in  DATA_W  read data from the controller.
- iread_ack  in  1  read completion from the controller.
- otimeout  out  1  sticky flag: an access was abandoned.

Function
REQ-005 Write slot: iwr_valid with owr_busy=0 SHALL latch iwr_addr/iwr_data and set owr_busy on the next edge; iwr_valid while owr_busy=1 SHALL be ignored (no overwrite).
REQ-006 Read slot: ird_valid with ord_busy=0 SHALL latch ird_addr and set ord_busy; ird_valid while ord_busy=1 SHALL be ignored.
REQ-007 FSM states SHALL be IDLE, WRITE, WDONE, READ, RDONE (one-hot).
REQ-008 IDLE SHALL behave as follows:
- Only write slot busy: go to WRITE.
- Only read slot busy: go to READ.
- Both busy: grant the port not granted last (round-robin), write first after reset.
- Neither busy: stay in IDLE.
REQ-009 owrite_req SHALL be registered and high exactly while in WRITE; oread_req SHALL be registered and high exactly while in READ; both SHALL never be high together.
REQ-010 owrite_address/owrite_data SHALL drive the latched write slot contents and remain stable while owrite_req=1; oread_address likewise for the read slot.
REQ-011 WRITE: iwrite_ack=1 SHALL go to WDONE; in WDONE owr_busy SHALL clear; WDONE SHALL last one cycle, then IDLE.
REQ-012 READ: iread_ack=1 SHALL capture iread_data into ord_data and go to RDONE; in RDONE ord_valid=1 and ord_busy clears; RDONE SHALL last one cycle, then IDLE.
REQ-013 Latency: a slot set while in IDLE with the other slot empty SHALL see its req high 2 cycles after the request (1 cycle to latch, 1 cycle to enter the state).
REQ-014 A slot SHALL accept a new request the cycle after its busy flag clears; a request in the DONE cycle itself SHALL be ignored.
REQ-015 iwrite_ack outside WRITE and iread_ack outside READ SHALL be ignored.
REQ-016 Timeout:
- A cycle counter SHALL clear on entry to WRITE/READ and increment each cycle in those states.
- If it reaches TIMEOUT-1 without an ack: req deasserts, otimeout sets, the slot is cleared (data discarded, no ord_valid), FSM goes to IDLE.
- An ack arriving in the same cycle as the timeout SHALL win (normal completion).
REQ-017 otimeout SHALL remain set until reset.

Reset
REQ-018 Asynchronous ireset=1 SHALL immediately force:
- FSM to IDLE.
- owr_busy, ord_busy, owrite_req, oread_req, ord_valid, otimeout to 0.
- ord_data, addresses, owrite_data to 0.
- Round-robin pointer to write-first.
REQ-019 Reset mid-access SHALL abandon the access with no ack processing; requests during reset SHALL be ignored.

Verification
REQ-020 Write iwr_addr=1, iwr_data=32'hDEADBEEF, ack 5 cycles after req -> owrite_req high 5 cycles, owr_busy clears in WDONE, no oread_req.
REQ-021 Read ird_addr=1, iread_data=0x23, ack 3 cycles later -> ord_data=0x23, ord_valid pulses once in RDONE.
REQ-022 Write and read requested in the same cycle, acks after 2 cycles -> WRITE first, then READ; a repeat of both -> WRITE then READ again, requests never overlap.
REQ-023 Write with no ack -> owrite_req drops after TIMEOUT cycles, otimeout=1, owr_busy=0; a following read completes normally with otimeout still 1.
REQ-024 Assert ireset during READ -> oread_req, ord_busy, ord_valid are 0 in the same cycle; a late iread_ack is ignored.
REQ-025 Second iwr_valid with data 0x55 while busy -> the controller still receives the first data; 0x55 is dropped.
